// File: rtl/cpu_host_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_host_loader
//  Purpose  : Host-side initiator for the CPU external memory ports.
//             1. Streams a program into instruction memory (IMEM ext port).
//             2. Holds cpu_enable high for a programmed number of cycles.
//             3. Reads a window of data memory (DMEM ext port) back out
//                as a 64-bit valid/ready stream.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    IMEM_WORDS  instruction memory depth, 32-bit words (byte addr = 4*i)
//    DMEM_WORDS  data memory depth, 64-bit words (byte addr = 8*i)
//    LEN_W       width of the length / index inputs
//  Ports
//    clk, arst_n              clock, asynchronous active-low reset
//    start                    1-cycle pulse, latches lengths (IDLE only)
//    load_len, run_cycles     program length / CPU run length
//    dump_base, dump_len      data memory readback window
//    s_valid/s_ready/s_data   program word input stream
//    m_valid/m_ready/m_data   dump word output stream
//    addr_ext, wen_ext, ren_ext, wdata_ext            IMEM ext port
//    addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
//    rdata_ext_2                                      DMEM ext port
//    cpu_enable               CPU run enable
//    busy, done               status (busy outside IDLE, done 1-cycle pulse)
//  Build option
//    LOADER_CHECKSUM_EN       adds load_csum[31:0] / dump_csum[63:0] outputs
//                             (XOR of accepted program words / emitted dump
//                             words, both cleared on an accepted start)
// ============================================================================
module cpu_host_loader #(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_WORDS = 128,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] load_len,
    input  logic [31:0]      run_cycles,
    input  logic [LEN_W-1:0] dump_base,
    input  logic [LEN_W-1:0] dump_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_data,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]      load_csum,
    output logic [63:0]      dump_csum
`endif
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [LEN_W-1:0] c_imem_words = LEN_W'(IMEM_WORDS);
    localparam logic [LEN_W-1:0] c_dmem_words = LEN_W'(DMEM_WORDS);
    localparam logic [LEN_W-1:0] c_one        = LEN_W'(1);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_RUN       = 3'd2,
        S_DUMP_RD   = 3'd3,
        S_DUMP_WAIT = 3'd4,
        S_DUMP_OUT  = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // ------------------------------------------------------------------
    // Latched sequence parameters and progress counters
    // ------------------------------------------------------------------
    logic [LEN_W-1:0] r_load_len;
    logic [31:0]      r_run_cycles;
    logic [LEN_W-1:0] r_dump_base;
    logic [LEN_W-1:0] r_dump_len;
    logic [LEN_W-1:0] r_load_cnt;
    logic [31:0]      r_run_cnt;
    logic [LEN_W-1:0] r_dump_cnt;

    // Registered IMEM write port, CPU enable and dump data holding register
    logic             r_wen;
    logic [63:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_cpu_en;
    logic [63:0]      r_m_data;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic             w_start_acc;
    logic             w_s_hs;
    logic             w_m_hs;
    logic             w_load_last;
    logic             w_run_end;
    logic             w_dump_last;
    logic [LEN_W-1:0] w_load_eff;
    logic [LEN_W-1:0] w_dump_avail;
    logic [LEN_W-1:0] w_dump_eff;
    logic [LEN_W-1:0] w_dump_idx;

    // start is only honoured in IDLE
    assign w_start_acc = (r_state == S_IDLE) && start;

    assign w_s_hs = s_valid && s_ready;
    assign w_m_hs = m_valid && m_ready;

    // Clamp the program length to the IMEM depth
    assign w_load_eff = (load_len > c_imem_words) ? c_imem_words : load_len;

    // Clamp the dump window so it never runs past the end of DMEM. The
    // subtraction wraps when dump_base is out of range, but that case is
    // forced to a zero length before the result is used.
    assign w_dump_avail = c_dmem_words - dump_base;
    assign w_dump_eff   = (dump_base >= c_dmem_words) ? '0 :
                          (dump_len > w_dump_avail)   ? w_dump_avail : dump_len;

    assign w_load_last = w_s_hs && (r_load_cnt == (r_load_len - c_one));
    assign w_run_end   = (r_run_cnt == r_run_cycles);
    assign w_dump_last = (r_dump_cnt == (r_dump_len - c_one));
    assign w_dump_idx  = r_dump_base + r_dump_cnt;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        s_ready      = 1'b0;
        ren_ext_2    = 1'b0;
        addr_ext_2   = '0;
        m_valid      = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (w_load_eff != '0) begin
                        w_next_state = S_LOAD;
                    end else if (run_cycles != 32'd0) begin
                        w_next_state = S_RUN;
                    end else if (w_dump_eff != '0) begin
                        w_next_state = S_DUMP_RD;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end
            end

            // A non-empty load always exits through RUN, even with a zero
            // run length: that single RUN cycle (cpu_enable stays low) lets
            // the registered write of the last word retire before the DMEM
            // port can become active.
            S_LOAD: begin
                s_ready = 1'b1;
                if (w_load_last) begin
                    w_next_state = S_RUN;
                end
            end

            S_RUN: begin
                if (w_run_end) begin
                    w_next_state = (r_dump_len != '0) ? S_DUMP_RD : S_DONE;
                end
            end

            S_DUMP_RD: begin
                ren_ext_2    = 1'b1;
                addr_ext_2   = {{(61-LEN_W){1'b0}}, w_dump_idx, 3'b000};
                w_next_state = S_DUMP_WAIT;
            end

            // Read data arrives this cycle and is captured into r_m_data
            S_DUMP_WAIT: begin
                w_next_state = S_DUMP_OUT;
            end

            S_DUMP_OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    w_next_state = w_dump_last ? S_DONE : S_DUMP_RD;
                end
            end

            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: latched parameters, counters, registered memory port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_load_len   <= '0;
            r_run_cycles <= '0;
            r_dump_base  <= '0;
            r_dump_len   <= '0;
            r_load_cnt   <= '0;
            r_run_cnt    <= '0;
            r_dump_cnt   <= '0;
            r_wen        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cpu_en     <= 1'b0;
            r_m_data     <= '0;
        end else begin
            // Single-cycle strobes by default
            r_wen    <= 1'b0;
            r_cpu_en <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_load_len   <= w_load_eff;
                        r_run_cycles <= run_cycles;
                        r_dump_base  <= dump_base;
                        r_dump_len   <= w_dump_eff;
                        r_load_cnt   <= '0;
                        r_run_cnt    <= '0;
                        r_dump_cnt   <= '0;
                    end
                end

                S_LOAD: begin
                    if (w_s_hs) begin
                        r_wen      <= 1'b1;
                        r_addr     <= {{(62-LEN_W){1'b0}}, r_load_cnt, 2'b00};
                        r_wdata    <= s_data;
                        r_load_cnt <= r_load_cnt + c_one;
                    end
                end

                // cpu_enable rises one cycle after RUN is entered and is
                // high for exactly r_run_cycles cycles; it is already low in
                // the first cycle after RUN.
                S_RUN: begin
                    if (!w_run_end) begin
                        r_cpu_en  <= 1'b1;
                        r_run_cnt <= r_run_cnt + 32'd1;
                    end
                end

                S_DUMP_WAIT: begin
                    r_m_data <= rdata_ext_2;
                end

                S_DUMP_OUT: begin
                    if (w_m_hs) begin
                        r_dump_cnt <= r_dump_cnt + c_one;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional checksums
    // ------------------------------------------------------------------
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_load_csum;
    logic [63:0] r_dump_csum;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_load_csum <= '0;
            r_dump_csum <= '0;
        end else if (w_start_acc) begin
            r_load_csum <= '0;
            r_dump_csum <= '0;
        end else begin
            if (w_s_hs) begin
                r_load_csum <= r_load_csum ^ s_data;
            end
            if (w_m_hs) begin
                r_dump_csum <= r_dump_csum ^ r_m_data;
            end
        end
    end

    assign load_csum = r_load_csum;
    assign dump_csum = r_dump_csum;
`else
    // Only the checksum logic consumes the accepted-start strobe
    logic w_unused;
    assign w_unused = w_start_acc;
`endif

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign addr_ext    = r_addr;
    assign wen_ext     = r_wen;
    assign wdata_ext   = r_wdata;
    assign ren_ext     = 1'b0;
    assign wen_ext_2   = 1'b0;
    assign wdata_ext_2 = '0;
    assign cpu_enable  = r_cpu_en;
    assign m_data      = r_m_data;

endmodule
`default_nettype wire

// File: tb/tb_cpu_host_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_host_loader
//  Purpose  : Self-checking bench for cpu_host_loader. Directed sequence in
//             one initial block; expected IMEM writes, DMEM read addresses
//             and dump words are queued when stimulus is driven and popped
//             as the DUT produces them. A small DMEM model answers reads.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_host_loader;

    logic        clk;
    logic        arst_n;
    logic        start;
    logic [15:0] load_len;
    logic [31:0] run_cycles;
    logic [15:0] dump_base;
    logic [15:0] dump_len;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2;
    logic        cpu_enable;
    logic        busy;
    logic        done;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] load_csum;
    logic [63:0] dump_csum;
`endif

    cpu_host_loader #(
        .IMEM_WORDS (128),
        .DMEM_WORDS (128),
        .LEN_W      (16)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .start       (start),
        .load_len    (load_len),
        .run_cycles  (run_cycles),
        .dump_base   (dump_base),
        .dump_len    (dump_len),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2),
        .cpu_enable  (cpu_enable),
        .busy        (busy),
        .done        (done)
`ifdef LOADER_CHECKSUM_EN
        ,
        .load_csum   (load_csum),
        .dump_csum   (dump_csum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_chk = 0;
    int n_err = 0;

    logic [63:0] exp_waddr [$];
    logic [31:0] exp_wdata [$];
    logic [63:0] exp_raddr [$];
    logic [63:0] exp_dump  [$];
    logic [63:0] dmem [0:127];

    // Cumulative event counts, written only by the monitor
    int wr_total = 0, wr_rises = 0, wr_unexp = 0;
    int en_total = 0, en_rises = 0;
    int rd_total = 0, rd_unexp = 0;
    int ovl_total = 0;
    bit wen_prev = 0, en_prev = 0;

    // Snapshots taken by the main sequence at the start of each scenario
    int snap_wr, snap_wr_r, snap_wr_u, snap_en, snap_en_r, snap_rd, snap_rd_u, snap_ovl;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // DMEM model: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (ren_ext_2 === 1'b1) begin
            rdata_ext_2 <= dmem[addr_ext_2[9:3]];
        end
    end

    // Monitor: scoreboard IMEM writes and DMEM read addresses, count
    // cpu_enable cycles and any port overlap.
    always @(negedge clk) begin
        if (wen_ext === 1'b1) begin
            wr_total++;
            if (!wen_prev) wr_rises++;
            if (exp_waddr.size() == 0) begin
                wr_unexp++;
            end else begin
                check("wr_addr", addr_ext, exp_waddr.pop_front());
                check("wr_data", {32'h0, wdata_ext}, {32'h0, exp_wdata.pop_front()});
            end
        end
        wen_prev = (wen_ext === 1'b1);

        if (cpu_enable === 1'b1) begin
            en_total++;
            if (!en_prev) en_rises++;
        end
        en_prev = (cpu_enable === 1'b1);

        if (ren_ext_2 === 1'b1) begin
            rd_total++;
            if (exp_raddr.size() == 0) rd_unexp++;
            else check("rd_addr", addr_ext_2, exp_raddr.pop_front());
        end

        if ((cpu_enable === 1'b1 && (wen_ext === 1'b1 || ren_ext_2 === 1'b1)) ||
            (wen_ext === 1'b1 && ren_ext_2 === 1'b1)) begin
            ovl_total++;
        end
    end

    // ------------------------------------------------------------------
    // Tasks
    // ------------------------------------------------------------------
    task automatic snapshot();
        snap_wr   = wr_total;  snap_wr_r = wr_rises; snap_wr_u = wr_unexp;
        snap_en   = en_total;  snap_en_r = en_rises;
        snap_rd   = rd_total;  snap_rd_u = rd_unexp;
        snap_ovl  = ovl_total;
    endtask

    task automatic flush();
        exp_waddr.delete(); exp_wdata.delete();
        exp_raddr.delete(); exp_dump.delete();
    endtask

    // Pulse start and queue the expected dump reads for the clamped window
    task automatic do_start(input int ll, input int rc, input int db, input int dl);
        int eff;
        @(posedge clk); #1;
        load_len   = 16'(ll);
        run_cycles = 32'(rc);
        dump_base  = 16'(db);
        dump_len   = 16'(dl);
        start      = 1'b1;
        if (db >= 128) eff = 0;
        else           eff = (dl < 128 - db) ? dl : 128 - db;
        for (int j = 0; j < eff; j++) begin
            exp_raddr.push_back(64'(8 * (db + j)));
            exp_dump.push_back(dmem[db + j]);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Start pulse that the DUT must ignore (no expectations queued)
    task automatic raw_start(input int ll, input int rc, input int db, input int dl);
        @(posedge clk); #1;
        load_len = 16'(ll); run_cycles = 32'(rc);
        dump_base = 16'(db); dump_len = 16'(dl);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Stream n words with s_valid held high (no gaps). pow2 selects 1<<k
    // instead of seed+k as the word value.
    task automatic send_words(input int n, input logic [31:0] seed, input bit pow2);
        int k;
        int guard;
        bit hs;
        k = 0;
        guard = 0;
        s_valid = 1'b1;
        while (k < n && guard < 1000) begin
            s_data = pow2 ? (32'h1 << k) : (seed + 32'(k));
            @(negedge clk);
            hs = (s_ready === 1'b1);
            if (hs) begin
                exp_waddr.push_back(64'(4 * k));
                exp_wdata.push_back(s_data);
            end
            @(posedge clk); #1;
            if (hs) k++;
            guard++;
        end
        s_valid = 1'b0;
        check("words_accepted", 64'(k), 64'(n));
    endtask

    task automatic recv_dump(input int n, input int stall0);
        int g;
        bit stable;
        logic [63:0] held;
        logic [63:0] e;
        for (int w = 0; w < n; w++) begin
            g = 0;
            stable = 1'b1;
            @(negedge clk);
            while (m_valid !== 1'b1 && g < 50) begin
                @(negedge clk);
                g++;
            end
            check("dump_valid", {63'h0, m_valid}, 64'h1);
            if (m_valid !== 1'b1) return;
            held = m_data;
            if (w == 0 && stall0 > 0) begin
                for (int s = 0; s < stall0; s++) begin
                    @(negedge clk);
                    if (m_valid !== 1'b1 || m_data !== held) stable = 1'b0;
                end
                check("dump_stall_stable", {63'h0, stable}, 64'h1);
            end
            e = (exp_dump.size() != 0) ? exp_dump.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
            check("dump_data", m_data, e);
            m_ready = 1'b1;
            @(posedge clk); #1;
            m_ready = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int g;
        g = 0;
        @(negedge clk);
        while (done !== 1'b1 && g < budget) begin
            @(negedge clk);
            g++;
        end
        check("done_seen", {62'h0, done, busy}, 64'h3);
        @(negedge clk);
        check("done_one_cycle_idle", {62'h0, done, busy}, 64'h0);
    endtask

    task automatic end_checks(input int e_wr, input int e_wr_r, input int e_en,
                              input int e_en_r, input int e_rd);
        check("wr_count",     64'(wr_total - snap_wr),   64'(e_wr));
        check("wr_bursts",    64'(wr_rises - snap_wr_r), 64'(e_wr_r));
        check("wr_unexpected",64'(wr_unexp - snap_wr_u), 64'h0);
        check("en_cycles",    64'(en_total - snap_en),   64'(e_en));
        check("en_pulses",    64'(en_rises - snap_en_r), 64'(e_en_r));
        check("rd_count",     64'(rd_total - snap_rd),   64'(e_rd));
        check("rd_unexpected",64'(rd_unexp - snap_rd_u), 64'h0);
        check("port_overlap", 64'(ovl_total - snap_ovl), 64'h0);
        check("queues_empty", 64'(exp_waddr.size() + exp_raddr.size() + exp_dump.size()), 64'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {57'h0, busy, done, s_ready, m_valid, wen_ext, ren_ext_2, cpu_enable}, 64'h0);
        check({tag, "_addr"}, addr_ext | addr_ext_2, 64'h0);
        check({tag, "_data"}, m_data | {32'h0, wdata_ext}, 64'h0);
        check({tag, "_fixed"}, wdata_ext_2 | {62'h0, ren_ext, wen_ext_2}, 64'h0);
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int g;
        arst_n = 1'b0; start = 1'b0; load_len = '0; run_cycles = '0;
        dump_base = '0; dump_len = '0; s_valid = 1'b0; s_data = '0;
        m_ready = 1'b0; rdata_ext_2 = '0;
        for (int i = 0; i < 128; i++) dmem[i] = {32'hD0D0_0000, 32'(i)};
        dmem[3] = 64'h11;
        dmem[4] = 64'h22;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        arst_n = 1'b1;

        // Reset in the middle of a load, after three accepted words
        snapshot();
        do_start(8, 5, 0, 1);
        send_words(3, 32'hC000_0000, 1'b0);
        arst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_load");
        check("reset_mid_load_writes", 64'(wr_total - snap_wr), 64'd2);
        flush();
        @(negedge clk);
        arst_n = 1'b1;

        // Gapless 4-word load restarting at address 0, run 3, no dump
        snapshot();
        do_start(4, 3, 0, 0);
        send_words(4, 32'hA0, 1'b0);
        @(negedge clk);
        check("sready_low_after_load", {62'h0, s_ready, busy}, 64'h1);
        wait_done(100);
        end_checks(4, 1, 3, 1, 0);

        // Run of exactly 10 cycles; a start during RUN must be ignored
        snapshot();
        do_start(2, 10, 0, 0);
        send_words(2, 32'hB0, 1'b0);
        g = 0;
        while (cpu_enable !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        raw_start(5, 3, 0, 4);
        wait_done(100);
        end_checks(2, 1, 10, 1, 0);

        // Reset while the CPU is enabled drops cpu_enable immediately
        do_start(0, 50, 0, 0);
        g = 0;
        @(negedge clk);
        while (cpu_enable !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("run_enable_high", {63'h0, cpu_enable}, 64'h1);
        arst_n = 1'b0;
        #1;
        check("reset_mid_run", {62'h0, cpu_enable, busy}, 64'h0);
        flush();
        @(negedge clk);
        arst_n = 1'b1;

        // Dump of DMEM[3..4] with a 5-cycle stall on the first word
        snapshot();
        do_start(1, 2, 3, 2);
        send_words(1, 32'hD0, 1'b0);
        recv_dump(2, 5);
        wait_done(100);
        end_checks(1, 1, 2, 1, 2);
`ifdef LOADER_CHECKSUM_EN
        check("dump_csum", dump_csum, 64'h33);
`endif

        // Oversized load clamps to 128 words; dump window clamps to 126..127
        snapshot();
        do_start(200, 1, 126, 10);
        send_words(128, 32'h5000_0000, 1'b0);
        s_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("sready_low_after_clamp", {63'h0, s_ready}, 64'h0);
        s_valid = 1'b0;
        recv_dump(2, 1);
        wait_done(100);
        end_checks(128, 1, 1, 1, 2);

        // Out-of-range dump base with no load and no run: straight to DONE
        snapshot();
        do_start(0, 0, 200, 5);
        wait_done(20);
        end_checks(0, 0, 0, 0, 0);

`ifdef LOADER_CHECKSUM_EN
        // Load checksum over words 1, 2, 4
        snapshot();
        do_start(3, 0, 0, 0);
        send_words(3, 32'h0, 1'b1);
        wait_done(50);
        check("load_csum", {32'h0, load_csum}, 64'h7);
        end_checks(3, 1, 0, 0, 0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
